// File: rtl/ctrl_spi_out_if.sv
// ctrl_spi_out_if
//   Bundles the request and SPI-line signals of the control-word SPI
//   transmitter (ctrl_spi_out).
//   Request side: i_data0 / i_data1 (16-bit words), i_send (start request).
//   Status side:  o_busy (frame in progress), o_done (one-cycle pulse at CS rise).
//   SPI lines:    o_SPI_CS (active low), o_SPI_clock (SCK, idles low),
//                 o_SPI_data (MOSI).
//   Modports: master = the block requesting frames, slave = the transmitter.
interface ctrl_spi_out_if;
  logic [15:0] i_data0;
  logic [15:0] i_data1;
  logic        i_send;
  logic        o_busy;
  logic        o_done;
  logic        o_SPI_CS;
  logic        o_SPI_clock;
  logic        o_SPI_data;

  modport master (
    output i_data0, i_data1, i_send,
    input  o_busy, o_done, o_SPI_CS, o_SPI_clock, o_SPI_data
  );

  modport slave (
    input  i_data0, i_data1, i_send,
    output o_busy, o_done, o_SPI_CS, o_SPI_clock, o_SPI_data
  );
endinterface

// File: rtl/ctrl_spi_out.sv
// ctrl_spi_out
//   SPI mode-0 master transmitter for the control-word link into the
//   oscillator FPGA. One request sends {i_data0, i_data1} MSB-first under a
//   single active-low chip select, then keeps CS high for a minimum gap
//   before accepting the next request.
//
//   Optional feature macro: CTRL_SPI_CHECKWORD_EN
//     defined   -> a third word (i_data0 ^ i_data1) is appended, 48-bit frame.
//     undefined -> 32-bit frame, no XOR logic.
//
//   Parameters:
//     CLK_DIV  SCK half-period in i_clock cycles (>=1)
//     CS_SETUP cycles from CS falling to first SCK rise (>=1)
//     CS_HOLD  cycles from last SCK fall to CS rise (>=1)
//     CS_GAP   CS-high cycles after a frame before o_busy drops (>=0)
//
//   Ports:
//     i_clock  system clock
//     rstn     asynchronous active-low reset (aborts any frame, no o_done)
//     bus      ctrl_spi_out_if.slave: i_data0, i_data1, i_send in;
//              o_busy, o_done, o_SPI_CS, o_SPI_clock, o_SPI_data out
//
//   All outputs come straight from registers, so the SPI lines are glitch
//   free. i_send is only looked at in IDLE; requests while busy are dropped.
module ctrl_spi_out #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic          i_clock,
  input  logic          rstn,
  ctrl_spi_out_if.slave bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SCK_HIGH = 3'd2;
  localparam logic [2:0] ST_SCK_LOW  = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

`ifdef CTRL_SPI_CHECKWORD_EN
  localparam int FRAME_BITS = 48;
`else
  localparam int FRAME_BITS = 32;
`endif

  // Phase counter must be able to count the longest of the timed phases.
  localparam int PH_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int PH_MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int PH_MAX   = (PH_MAX_A > PH_MAX_B) ? PH_MAX_A : PH_MAX_B;
  localparam int PH_W     = $clog2(PH_MAX + 1);

  // Each phase is loaded with (length - 1) and ends when the counter is 0,
  // so a phase of length L occupies exactly L cycles.
  localparam logic [PH_W-1:0] SETUP_LOAD = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] DIV_LOAD   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] HOLD_LOAD  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0] GAP_LOAD   = PH_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  logic [2:0]            state_reg, state_next;
  logic [PH_W-1:0]       phase_reg, phase_next;
  logic [5:0]            bits_reg, bits_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  cs_reg, cs_next;
  logic                  sck_reg, sck_next;

  logic [FRAME_BITS-1:0] frame_word;

`ifdef CTRL_SPI_CHECKWORD_EN
  logic [15:0] check_word;
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_check_word
    assign check_word[gi] = bus.i_data0[gi] ^ bus.i_data1[gi];
  end
  assign frame_word = {bus.i_data0, bus.i_data1, check_word};
`else
  assign frame_word = {bus.i_data0, bus.i_data1};
`endif

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    bits_next  = bits_reg;
    shift_next = shift_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    cs_next    = cs_reg;
    sck_next   = sck_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.i_send) begin
          shift_next = frame_word;
          bits_next  = 6'(FRAME_BITS);
          busy_next  = 1'b1;
          cs_next    = 1'b0;
          phase_next = SETUP_LOAD;
          state_next = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (phase_reg == '0) begin
          sck_next   = 1'b1;
          phase_next = DIV_LOAD;
          state_next = ST_SCK_HIGH;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end

      ST_SCK_HIGH: begin
        if (phase_reg == '0) begin
          // Falling edge: present the next bit. Zeros are shifted in, so
          // MOSI is 0 after the last bit without any extra logic.
          sck_next   = 1'b0;
          shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
          bits_next  = bits_reg - 6'd1;
          if (bits_reg == 6'd1) begin
            // The hold time starts at the last falling edge, so the final
            // low half-period is replaced by the CS hold phase.
            phase_next = HOLD_LOAD;
            state_next = ST_HOLD;
          end else begin
            phase_next = DIV_LOAD;
            state_next = ST_SCK_LOW;
          end
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end

      ST_SCK_LOW: begin
        if (phase_reg == '0) begin
          sck_next   = 1'b1;
          phase_next = DIV_LOAD;
          state_next = ST_SCK_HIGH;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end

      ST_HOLD: begin
        if (phase_reg == '0) begin
          cs_next   = 1'b1;
          done_next = 1'b1;
          if (CS_GAP == 0) begin
            // No gap: busy drops together with the CS rise / done pulse.
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            phase_next = GAP_LOAD;
            state_next = ST_GAP;
          end
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end

      ST_GAP: begin
        if (phase_reg == '0) begin
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        cs_next    = 1'b1;
        sck_next   = 1'b0;
        shift_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      bits_reg  <= '0;
      shift_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cs_reg    <= 1'b1;
      sck_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      bits_reg  <= bits_next;
      shift_reg <= shift_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      cs_reg    <= cs_next;
      sck_reg   <= sck_next;
    end
  end

  assign bus.o_busy      = busy_reg;
  assign bus.o_done      = done_reg;
  assign bus.o_SPI_CS    = cs_reg;
  assign bus.o_SPI_clock = sck_reg;
  assign bus.o_SPI_data  = shift_reg[FRAME_BITS-1];

endmodule
